// File: rtl/ab_writeback.sv
// ab_writeback: commits decoder A/B/ZNC results under opCode write masks,
// forwards each committed state through a 2-entry FWFT FIFO, counts retirements.
`default_nettype none

module ab_writeback #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      opCode,
   input  logic [15:0]      A_in,
   input  logic [15:0]      B_in,
   input  logic [2:0]       ZNC_in,
   output logic [15:0]      A_reg,
   output logic [15:0]      B_reg,
   output logic [2:0]       ZNC_reg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_A,
   output logic [15:0]      out_B,
   output logic [2:0]       out_ZNC,
   output logic [1:0]       out_unit,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int         REC_W = 16 + 16 + 3 + 2;
   localparam logic [1:0] FULL  = 2'(DEPTH);

   logic [REC_W-1:0] mem [0:1];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;

   logic             accept;
   logic             pop;
   logic [15:0]      a_next;
   logic [15:0]      b_next;
   logic [2:0]       znc_next;
   logic [REC_W-1:0] head;
   logic             unused_op;

   assign unused_op = ^opCode[10:0];

   // in_ready is a function of the occupancy alone, never of out_ready.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      a_next   = opCode[13] ? A_in : A_reg;
      b_next   = opCode[12] ? B_in : B_reg;
      znc_next = opCode[11] ? ZNC_reg : ZNC_in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         A_reg      <= '0;
         B_reg      <= '0;
         ZNC_reg    <= '0;
         retire_cnt <= '0;
      end else if (accept) begin
         A_reg      <= a_next;
         B_reg      <= b_next;
         ZNC_reg    <= znc_next;
         retire_cnt <= retire_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         // The record holds the post-update architectural state, not raw inputs.
         if (accept) begin
            mem[wr_ptr] <= {a_next, b_next, znc_next, opCode[15:14]};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head     = mem[rd_ptr];
   assign out_A    = head[36:21];
   assign out_B    = head[20:5];
   assign out_ZNC  = head[4:2];
   assign out_unit = head[1:0];

endmodule

`default_nettype wire

// File: tb/tb_ab_writeback.sv
// tb_ab_writeback: directed vector table, corner sequences and random traffic
// checked against a queue-based reference model of the writeback stage.
`default_nettype none

module tb_ab_writeback;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] opCode;
   logic [15:0] A_in;
   logic [15:0] B_in;
   logic [2:0]  ZNC_in;
   logic [15:0] A_reg;
   logic [15:0] B_reg;
   logic [2:0]  ZNC_reg;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_A;
   logic [15:0] out_B;
   logic [2:0]  out_ZNC;
   logic [1:0]  out_unit;
   logic [15:0] retire_cnt;

   ab_writeback #(.DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opCode     (opCode),
      .A_in       (A_in),
      .B_in       (B_in),
      .ZNC_in     (ZNC_in),
      .A_reg      (A_reg),
      .B_reg      (B_reg),
      .ZNC_reg    (ZNC_reg),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_A      (out_A),
      .out_B      (out_B),
      .out_ZNC    (out_ZNC),
      .out_unit   (out_unit),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  znc;
      logic [1:0]  unit;
   } rec_t;

   typedef struct {
      logic        v;
      logic [15:0] op;
      logic [15:0] a_in;
      logic [15:0] b_in;
      logic [2:0]  z_in;
      logic        ordy;
      logic [15:0] e_a;
      logic [15:0] e_b;
      logic [2:0]  e_z;
      logic        e_ov;
      logic [1:0]  e_unit;
      logic [15:0] e_outa;
      logic [15:0] e_cnt;
      logic        e_ir;
   } vec_t;

   rec_t        q[$];
   logic [15:0] m_a, m_b, m_cnt;
   logic [2:0]  m_z;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_a = '0; m_b = '0; m_z = '0; m_cnt = '0;
   endtask

   // Reference behaviour for one clock edge, using the inputs held across it.
   task automatic model_edge();
      bit   acc;
      bit   pp;
      rec_t r;
      acc = in_valid && (q.size() != 2);
      pp  = (q.size() != 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc) begin
         if (opCode[13]) m_a = A_in;
         if (opCode[12]) m_b = B_in;
         if (!opCode[11]) m_z = ZNC_in;
         m_cnt = m_cnt + 16'd1;
         r.a = m_a; r.b = m_b; r.znc = m_z; r.unit = opCode[15:14];
         q.push_back(r);
      end
   endtask

   task automatic check_model();
      chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("A_reg", 32'(A_reg), 32'(m_a));
      chk("B_reg", 32'(B_reg), 32'(m_b));
      chk("ZNC_reg", 32'(ZNC_reg), 32'(m_z));
      chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
      if (q.size() != 0) begin
         chk("out_A", 32'(out_A), 32'(q[0].a));
         chk("out_B", 32'(out_B), 32'(q[0].b));
         chk("out_ZNC", 32'(out_ZNC), 32'(q[0].znc));
         chk("out_unit", 32'(out_unit), 32'(q[0].unit));
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] z, input logic ordy);
      in_valid = v; opCode = op; A_in = a; B_in = b; ZNC_in = z; out_ready = ordy;
   endtask

   task automatic step(input bit do_check);
      @(posedge clk);
      model_edge();
      #1;
      if (do_check) check_model();
   endtask

   vec_t vecs[7];

   initial begin
      logic [15:0] cnt0;
      logic [15:0] a_save;

      vecs[0] = '{1'b1, 16'h7000, 16'h1234, 16'hABCD, 3'b101, 1'b0,
                  16'h1234, 16'hABCD, 3'b101, 1'b1, 2'b01, 16'h1234, 16'd1, 1'b1};
      vecs[1] = '{1'b1, 16'hC800, 16'hFFFF, 16'hFFFF, 3'b000, 1'b0,
                  16'h1234, 16'hABCD, 3'b101, 1'b1, 2'b01, 16'h1234, 16'd2, 1'b0};
      vecs[2] = '{1'b1, 16'h2000, 16'h5555, 16'h0000, 3'b011, 1'b0,
                  16'h1234, 16'hABCD, 3'b101, 1'b1, 2'b01, 16'h1234, 16'd2, 1'b0};
      vecs[3] = '{1'b1, 16'h2000, 16'h5555, 16'h0000, 3'b011, 1'b1,
                  16'h1234, 16'hABCD, 3'b101, 1'b1, 2'b11, 16'h1234, 16'd2, 1'b1};
      vecs[4] = '{1'b1, 16'h2000, 16'h5555, 16'h0000, 3'b011, 1'b0,
                  16'h5555, 16'hABCD, 3'b011, 1'b1, 2'b11, 16'h1234, 16'd3, 1'b0};
      vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b1,
                  16'h5555, 16'hABCD, 3'b011, 1'b1, 2'b00, 16'h5555, 16'd3, 1'b1};
      vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b1,
                  16'h5555, 16'hABCD, 3'b011, 1'b0, 2'b00, 16'h5555, 16'd3, 1'b1};

      drive(1'b0, '0, '0, '0, '0, 1'b0);
      reset_n = 1'b0;
      model_reset();
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst A_reg", 32'(A_reg), 32'd0);
      chk("rst retire_cnt", 32'(retire_cnt), 32'd0);
      chk("rst out_A", 32'(out_A), 32'd0);
      chk("rst out_unit", 32'(out_unit), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1);

      // Directed table: accept, mask-only accept, backpressure, pop, refill, drain.
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].a_in, vecs[i].b_in, vecs[i].z_in, vecs[i].ordy);
         step(1'b1);
         chk($sformatf("vec%0d A_reg", i), 32'(A_reg), 32'(vecs[i].e_a));
         chk($sformatf("vec%0d B_reg", i), 32'(B_reg), 32'(vecs[i].e_b));
         chk($sformatf("vec%0d ZNC_reg", i), 32'(ZNC_reg), 32'(vecs[i].e_z));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            chk($sformatf("vec%0d out_unit", i), 32'(out_unit), 32'(vecs[i].e_unit));
            chk($sformatf("vec%0d out_A", i), 32'(out_A), 32'(vecs[i].e_outa));
         end
         chk($sformatf("vec%0d retire_cnt", i), 32'(retire_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      end

      // Steady push+pop at occupancy 1 for 10 cycles.
      drive(1'b1, {2'($urandom), 14'h3000}, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0);
      step(1'b1);
      cnt0 = retire_cnt;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'b1);
         step(1'b1);
         chk("pp out_valid", 32'(out_valid), 32'd1);
         chk("pp in_ready", 32'(in_ready), 32'd1);
      end
      chk("pp retire delta", 32'(retire_cnt - cnt0), 32'd10);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
               ($urandom_range(0, 3) != 0));
         step(1'b1);
      end

      // Fill to two entries, then reset asynchronously away from any edge.
      drive(1'b1, 16'h7000, 16'h1111, 16'h2222, 3'b111, 1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("full in_ready", 32'(in_ready), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst retire_cnt", 32'(retire_cnt), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst A_reg", 32'(A_reg), 32'd0);
      model_reset();
      drive(1'b0, '0, '0, '0, '0, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1);

      // Counter wrap: mask-only accepts leave the registers alone.
      drive(1'b1, 16'h7000, 16'hBEEF, 16'hCAFE, 3'b010, 1'b1);
      step(1'b1);
      a_save = A_reg;
      while (m_cnt != 16'hFFFF) begin
         drive(1'b1, {2'($urandom), 14'h0800}, 16'($urandom), 16'($urandom), 3'($urandom), 1'b1);
         step(1'b0);
      end
      check_model();
      chk("wrap pre", 32'(retire_cnt), 32'hFFFF);
      drive(1'b1, 16'h0800, 16'h0000, 16'h0000, 3'b000, 1'b1);
      step(1'b1);
      chk("wrap post", 32'(retire_cnt), 32'h0000);
      chk("wrap A_reg", 32'(A_reg), 32'(a_save));
      chk("wrap B_reg", 32'(B_reg), 32'hCAFE);
      chk("wrap ZNC_reg", 32'(ZNC_reg), 32'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
